// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int DEFAULT_TIMEOUT = 16;

  // Register $zero never carries a real dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// E-stage operand bypass select for one source register; M result beats W result.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] WriteRegM,
  input  logic       RegWriteM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteW,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (RegWriteM && reg_match(WriteRegM, src)) begin
      sel = FWD_MEM;
    end else if (RegWriteW && reg_match(WriteRegW, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipe, with a memory-wait freeze FSM
// and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  state_t            state, state_next;
  logic [WAIT_W-1:0] waitcnt;
  logic              mem_err;
  logic              freeze;
  logic              lwstall, branchstall, hz;

  assign lwstall = MemtoRegE && (reg_match(RtE, RsD) || reg_match(RtE, RtD));
  assign branchstall = BranchD &&
      ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
       (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
  assign hz = lwstall || branchstall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (MemReqM && !MemReadyM) state_next = MEM_WAIT;
      MEM_WAIT: begin
        // Ready on the last allowed cycle still counts as a completed access.
        if (MemReadyM)                            state_next = RUN;
        else if (waitcnt == WAIT_W'(TIMEOUT - 1)) state_next = MEM_ERR;
      end
      MEM_ERR:  state_next = MEM_ERR;
      default:  state_next = RUN;
    endcase
  end

  always_comb begin
    freeze = ((state == RUN) && MemReqM && !MemReadyM) ||
             ((state == MEM_WAIT) && !MemReadyM) ||
             (state == MEM_ERR);
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (freeze) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else begin
      StallF = hz;
      StallD = hz;
      FlushE = hz;
      FlushD = PCSrcD && !hz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitcnt <= '0;
      mem_err <= 1'b0;
    end else begin
      waitcnt <= (state == MEM_WAIT) ? waitcnt + WAIT_W'(1) : '0;
      mem_err <= mem_err || (state_next == MEM_ERR);
    end
  end

  assign MemErr = mem_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1))             StallCnt <= StallCnt + CNT_W'(1);
      if ((FlushD || FlushE) && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

  forward_sel u_fwd_a (
    .src(RsE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .sel(ForwardAE)
  );

  forward_sel u_fwd_b (
    .src(RtE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .sel(ForwardBE)
  );

  assign ForwardAD = RegWriteM && reg_match(WriteRegM, RsD);
  assign ForwardBD = RegWriteM && reg_match(WriteRegM, RtD);

endmodule
